// File: rtl/fu_alg_pkg.sv
//==============================================================================
// Module      : fu_alg_pkg
// Description : Shared types and region constants for the alignment bypass
//               mux control path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fu_alg_pkg;

    // Bit ranges of the 163-bit aligner result
    localparam int unsigned c_REG_ADD_LSB  = 0;
    localparam int unsigned c_REG_ADD_MSB  = 52;
    localparam int unsigned c_REG_HI_LSB   = 53;
    localparam int unsigned c_REG_HI_MSB   = 98;
    localparam int unsigned c_REG_LOHI_LSB = 99;
    localparam int unsigned c_REG_LOHI_MSB = 130;
    localparam int unsigned c_REG_LO_LSB   = 131;
    localparam int unsigned c_REG_LO_MSB   = 162;
    localparam int unsigned c_ALIGN_W      = 163;

    typedef logic [0:0] state_t;
    localparam state_t c_ST_IDLE  = 1'b0;
    localparam state_t c_ST_PASS2 = 1'b1;

    typedef struct packed {
        logic v;
        logic byp;
        logic sub;
        logic is_int;
        logic dw;
    } ex_ctl_t;

endpackage

`default_nettype wire

// File: rtl/fu_alg_bypctl_dec.sv
//==============================================================================
// Module      : fu_alg_bypctl_dec
// Description : Combinational decode of ex3 controls and drain state into the
//               region selects, result qualifiers and ex1/ex2 hold.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fu_alg_bypctl_dec
    import fu_alg_pkg::*;
#(
    parameter bit INT_DW_EN = 1'b1
) (
    input  ex_ctl_t i_ex3,
    input  state_t  i_state,
    output logic    o_byp_sel_pos,
    output logic    o_byp_sel_neg,
    output logic    o_byp_sel_byp_pos,
    output logic    o_byp_sel_byp_neg,
    output logic    o_prd_sel_pos_hi,
    output logic    o_prd_sel_neg_hi,
    output logic    o_prd_sel_pos_lohi,
    output logic    o_prd_sel_neg_lohi,
    output logic    o_prd_sel_pos_lo,
    output logic    o_prd_sel_neg_lo,
    output logic    o_res_valid,
    output logic    o_res_hi,
    output logic    o_hold
);

    logic w_dw;
    assign w_dw = i_ex3.is_int & i_ex3.dw & INT_DW_EN;

    always_comb begin
        o_byp_sel_pos      = 1'b0;
        o_byp_sel_neg      = 1'b0;
        o_byp_sel_byp_pos  = 1'b0;
        o_byp_sel_byp_neg  = 1'b0;
        o_prd_sel_pos_hi   = 1'b0;
        o_prd_sel_neg_hi   = 1'b0;
        o_prd_sel_pos_lohi = 1'b0;
        o_prd_sel_neg_lohi = 1'b0;
        o_prd_sel_pos_lo   = 1'b0;
        o_prd_sel_neg_lo   = 1'b0;
        o_res_valid        = 1'b0;
        o_res_hi           = 1'b0;
        o_hold             = 1'b0;
        if (i_ex3.v) begin
            o_res_valid = 1'b1;
            if (!i_ex3.is_int) begin
                if (i_ex3.byp) begin
                    // Pass fraction only; product regions read zero
                    o_byp_sel_byp_pos = ~i_ex3.sub;
                    o_byp_sel_byp_neg = i_ex3.sub;
                end else begin
                    o_byp_sel_pos      = ~i_ex3.sub;
                    o_byp_sel_neg      = i_ex3.sub;
                    o_prd_sel_pos_hi   = ~i_ex3.sub;
                    o_prd_sel_neg_hi   = i_ex3.sub;
                    o_prd_sel_pos_lohi = ~i_ex3.sub;
                    o_prd_sel_neg_lohi = i_ex3.sub;
                    o_prd_sel_pos_lo   = ~i_ex3.sub;
                    o_prd_sel_neg_lo   = i_ex3.sub;
                end
            end else if (!w_dw) begin
                o_prd_sel_pos_lohi = ~i_ex3.sub;
                o_prd_sel_neg_lohi = i_ex3.sub;
                o_prd_sel_pos_lo   = ~i_ex3.sub;
                o_prd_sel_neg_lo   = i_ex3.sub;
            end else if (i_state == c_ST_PASS2) begin
                o_prd_sel_pos_lohi = ~i_ex3.sub;
                o_prd_sel_neg_lohi = i_ex3.sub;
                o_res_hi           = 1'b1;
            end else begin
                // First pass of a 64-bit drain: low word, keep the pipe held
                o_prd_sel_pos_lo = ~i_ex3.sub;
                o_prd_sel_neg_lo = i_ex3.sub;
                o_hold           = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fu_alg_bypctl.sv
//==============================================================================
// Module      : fu_alg_bypctl
// Description : ex1->ex3 control pipeline and two-pass drain sequencer for the
//               alignment bypass mux selects.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fu_alg_bypctl
    import fu_alg_pkg::*;
#(
    parameter bit INT_DW_EN = 1'b1
) (
    input  logic nclk,
    input  logic rst_n,
    input  logic ex1_valid,
    input  logic ex1_byp,
    input  logic ex1_eff_sub,
    input  logic ex1_int,
    input  logic ex1_int_dw,
    input  logic flush,
    input  logic stall,
    output logic ex3_byp_sel_pos,
    output logic ex3_byp_sel_neg,
    output logic ex3_byp_sel_byp_pos,
    output logic ex3_byp_sel_byp_neg,
    output logic ex3_prd_sel_pos_hi,
    output logic ex3_prd_sel_neg_hi,
    output logic ex3_prd_sel_pos_lohi,
    output logic ex3_prd_sel_neg_lohi,
    output logic ex3_prd_sel_pos_lo,
    output logic ex3_prd_sel_neg_lo,
    output logic ex3_res_valid,
    output logic ex3_res_hi,
    output logic ex3_hold
);

    ex_ctl_t r_ex2;
    ex_ctl_t r_ex3;
    ex_ctl_t w_ex1;
    state_t  r_state;
    state_t  w_state_nxt;
    logic    w_hold;
    logic    w_adv;

    assign w_ex1.v      = ex1_valid;
    assign w_ex1.byp    = ex1_byp;
    assign w_ex1.sub    = ex1_eff_sub;
    assign w_ex1.is_int = ex1_int;
    assign w_ex1.dw     = ex1_int_dw & ex1_int;

    assign w_adv    = ~stall & ~w_hold;
    assign ex3_hold = w_hold;

    always_ff @(posedge nclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex2 <= '0;
            r_ex3 <= '0;
        end else begin
            if (w_adv) begin
                r_ex2 <= w_ex1;
                r_ex3 <= r_ex2;
            end
            // Flush kills what is already in ex2/ex3; a fresh ex1 capture survives
            if (flush) begin
                r_ex3.v <= 1'b0;
                if (!w_adv) begin
                    r_ex2.v <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge nclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_ST_IDLE;
        end else if (!stall) begin
            case (r_state)
                c_ST_IDLE:  if (w_hold) w_state_nxt = c_ST_PASS2;
                c_ST_PASS2: w_state_nxt = c_ST_IDLE;
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    fu_alg_bypctl_dec #(
        .INT_DW_EN (INT_DW_EN)
    ) u_dec (
        .i_ex3              (r_ex3),
        .i_state            (r_state),
        .o_byp_sel_pos      (ex3_byp_sel_pos),
        .o_byp_sel_neg      (ex3_byp_sel_neg),
        .o_byp_sel_byp_pos  (ex3_byp_sel_byp_pos),
        .o_byp_sel_byp_neg  (ex3_byp_sel_byp_neg),
        .o_prd_sel_pos_hi   (ex3_prd_sel_pos_hi),
        .o_prd_sel_neg_hi   (ex3_prd_sel_neg_hi),
        .o_prd_sel_pos_lohi (ex3_prd_sel_pos_lohi),
        .o_prd_sel_neg_lohi (ex3_prd_sel_neg_lohi),
        .o_prd_sel_pos_lo   (ex3_prd_sel_pos_lo),
        .o_prd_sel_neg_lo   (ex3_prd_sel_neg_lo),
        .o_res_valid        (ex3_res_valid),
        .o_res_hi           (ex3_res_hi),
        .o_hold             (w_hold)
    );

endmodule

`default_nettype wire

// File: tb/tb_fu_alg_bypctl.sv
//==============================================================================
// Module      : tb_fu_alg_bypctl
// Description : Directed, table-driven self-checking bench for fu_alg_bypctl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fu_alg_bypctl;

    logic nclk;
    logic rst_n;
    logic ex1_valid, ex1_byp, ex1_eff_sub, ex1_int, ex1_int_dw;
    logic flush, stall;
    logic byp_pos, byp_neg, byp_byp_pos, byp_byp_neg;
    logic pos_hi, neg_hi, pos_lohi, neg_lohi, pos_lo, neg_lo;
    logic res_valid, res_hi, hold;

    int n_checks;
    int n_fail;

    fu_alg_bypctl #(.INT_DW_EN(1'b1)) dut (
        .nclk                 (nclk),
        .rst_n                (rst_n),
        .ex1_valid            (ex1_valid),
        .ex1_byp              (ex1_byp),
        .ex1_eff_sub          (ex1_eff_sub),
        .ex1_int              (ex1_int),
        .ex1_int_dw           (ex1_int_dw),
        .flush                (flush),
        .stall                (stall),
        .ex3_byp_sel_pos      (byp_pos),
        .ex3_byp_sel_neg      (byp_neg),
        .ex3_byp_sel_byp_pos  (byp_byp_pos),
        .ex3_byp_sel_byp_neg  (byp_byp_neg),
        .ex3_prd_sel_pos_hi   (pos_hi),
        .ex3_prd_sel_neg_hi   (neg_hi),
        .ex3_prd_sel_pos_lohi (pos_lohi),
        .ex3_prd_sel_neg_lohi (neg_lohi),
        .ex3_prd_sel_pos_lo   (pos_lo),
        .ex3_prd_sel_neg_lo   (neg_lo),
        .ex3_res_valid        (res_valid),
        .ex3_res_hi           (res_hi),
        .ex3_hold             (hold)
    );

    initial nclk = 1'b0;
    always #5 nclk = ~nclk;

    // Output vector order: byp_pos byp_neg byp_byp_pos byp_byp_neg |
    // pos_hi neg_hi pos_lohi neg_lohi pos_lo neg_lo | res_valid res_hi hold
    localparam logic [12:0] c_ZERO       = 13'b0000_000000_000;
    localparam logic [12:0] c_FP_ADD     = 13'b1000_101010_100;
    localparam logic [12:0] c_FP_SUB     = 13'b0100_010101_100;
    localparam logic [12:0] c_BYP_POS    = 13'b0010_000000_100;
    localparam logic [12:0] c_BYP_NEG    = 13'b0001_000000_100;
    localparam logic [12:0] c_INT_POS    = 13'b0000_001010_100;
    localparam logic [12:0] c_INT_NEG    = 13'b0000_000101_100;
    localparam logic [12:0] c_DW1_POS    = 13'b0000_000010_101;
    localparam logic [12:0] c_DW1_NEG    = 13'b0000_000001_101;
    localparam logic [12:0] c_DW2_POS    = 13'b0000_001000_110;
    localparam logic [12:0] c_DW2_NEG    = 13'b0000_000100_110;

    typedef struct packed {
        logic        v;
        logic        byp;
        logic        sub;
        logic        is_int;
        logic        dw;
        logic [12:0] e1;
        logic [12:0] e2;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [12:0] outs();
        return {byp_pos, byp_neg, byp_byp_pos, byp_byp_neg,
                pos_hi, neg_hi, pos_lohi, neg_lohi, pos_lo, neg_lo,
                res_valid, res_hi, hold};
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = outs();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge nclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic s,
                         input logic i, input logic d);
        ex1_valid   = v;
        ex1_byp     = b;
        ex1_eff_sub = s;
        ex1_int     = i;
        ex1_int_dw  = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        flush    = 1'b0;
        stall    = 1'b0;
        idle();
        rst_n    = 1'b0;

        //            v    byp  sub  int  dw   cycle 2     cycle 3
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c_FP_ADD,  c_ZERO};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, c_FP_SUB,  c_ZERO};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, c_BYP_NEG, c_ZERO};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c_BYP_POS, c_ZERO};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c_INT_POS, c_ZERO};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, c_INT_NEG, c_ZERO};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c_FP_ADD,  c_ZERO};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, c_DW1_NEG, c_DW2_NEG};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, c_DW1_POS, c_DW2_POS};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, c_ZERO,    c_ZERO};

        tick();
        check("reset_during", c_ZERO);
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_after", c_ZERO);

        for (int k = 0; k < 10; k++) begin
            drive(vecs[k].v, vecs[k].byp, vecs[k].sub, vecs[k].is_int, vecs[k].dw);
            tick();
            idle();
            tick();
            check($sformatf("vec%0d_c2", k), vecs[k].e1);
            tick();
            check($sformatf("vec%0d_c3", k), vecs[k].e2);
            tick();
            tick();
        end

        // Back-to-back bypass ops with opposite polarity
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("b2b_byp_c2", c_BYP_NEG);
        tick();
        check("b2b_byp_c3", c_BYP_POS);
        tick();
        tick();

        // int_dw followed by an FP op
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("dw_fp_c2", c_DW1_NEG);
        tick();
        check("dw_fp_c3", c_DW2_NEG);
        tick();
        check("dw_fp_c4", c_FP_ADD);
        tick();
        check("dw_fp_c5", c_ZERO);
        tick();

        // int_dw with stall in cycles 2-3; op B waits in ex1 until accepted
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        stall = 1'b1;
        check("stall_c2", c_DW1_POS);
        tick();
        check("stall_c3", c_DW1_POS);
        tick();
        stall = 1'b0;
        check("stall_c4", c_DW1_POS);
        tick();
        check("stall_c5", c_DW2_POS);
        tick();
        idle();
        check("stall_c6", c_FP_ADD);
        tick();
        check("stall_c7", c_FP_SUB);
        tick();
        check("stall_c8", c_ZERO);
        tick();

        // Flush during PASS2 kills the dw op and the FP op behind it
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("flush_c2", c_DW1_NEG);
        tick();
        check("flush_c3", c_DW2_NEG);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_c4", c_ZERO);
        tick();
        check("flush_c5", c_ZERO);
        // A new dw op must start at pass 1, proving the FSM returned to IDLE
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        check("flush_idle_c2", c_DW1_POS);
        tick();
        check("flush_idle_c3", c_DW2_POS);
        tick();

        // Asynchronous reset mid-PASS2
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        tick();
        check("arst_pass2", c_DW2_NEG);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_async", c_ZERO);
        tick();
        rst_n = 1'b1;
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        check("arst_int_c2", c_INT_POS);
        tick();
        check("arst_int_c3", c_ZERO);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
